// File: rtl/skid_fifo_crd_pkg.sv
// Shared helpers for the skid_fifo_crd AXI-Stream register FIFO.
// Beat width helpers; the beat struct itself is declared in skid_fifo_crd from these widths.
package skid_fifo_crd_pkg;

  function automatic int unsigned nb_of(input int unsigned n);
    return n * 8;
  endfunction

  function automatic int unsigned beat_w(input int unsigned n);
    return nb_of(n) + n + 1;
  endfunction

endpackage

// File: rtl/skid_fifo_crd_ram.sv
// Flop storage for skid_fifo_crd: one write port plus a registered read port that
// can forward the incoming beat straight into the output register.
module skid_fifo_crd_ram #(
  parameter int unsigned W     = 37,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic          aclk,
  input  logic          areset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  input  logic          bypass,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge aclk) begin
    if (we) mem[waddr] <= wdata;
  end

  // raddr is the head index after this edge's read; bypass covers a write into an empty FIFO
  always_ff @(posedge aclk) begin
    if (areset) rdata <= '0;
    else        rdata <= bypass ? wdata : mem[raddr];
  end

endmodule

// File: rtl/skid_fifo_crd.sv
// N-byte AXI-Stream register FIFO with registered ready/valid and occupancy output.
// Optional store-and-forward behaviour: define SKID_FIFO_CRD_PACKET_MODE_EN.
module skid_fifo_crd
  import skid_fifo_crd_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic                aclk,
  input  logic                areset,
  input  logic [nb_of(N)-1:0] in_tdata,
  input  logic [N-1:0]        in_tkeep,
  input  logic                in_tlast,
  input  logic                in_tvalid,
  output logic                in_tready,
  output logic [nb_of(N)-1:0] out_tdata,
  output logic [N-1:0]        out_tkeep,
  output logic                out_tlast,
  output logic                out_tvalid,
  input  logic                out_tready,
  output logic [AW:0]         occupancy
);

  localparam int unsigned NB   = nb_of(N);
  localparam int unsigned BW   = beat_w(N);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [NB-1:0] tdata;
    logic [N-1:0]  tkeep;
    logic          tlast;
  } beat_t;

  logic [AW:0]   count, count_ar, count_next;
  logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_next;
  logic          wr, rd, bypass, vld_next;
  beat_t         wbeat, head;
  logic [BW-1:0] rdata;

  assign wr          = in_tvalid & in_tready;
  assign rd          = out_tvalid & out_tready;
  assign count_ar    = count - (AW+1)'(rd);
  assign count_next  = count_ar + (AW+1)'(wr);
  assign rd_ptr_next = rd_ptr + AW'(rd);
  assign bypass      = wr & (count_ar == '0);
  assign wbeat       = '{tdata: in_tdata, tkeep: in_tkeep, tlast: in_tlast};

`ifdef SKID_FIFO_CRD_PACKET_MODE_EN
  logic [AW:0] pkt_cnt, pkt_next;
  logic        ct, ct_next, wr_last, rd_last;

  assign wr_last = wr & in_tlast;
  assign rd_last = rd & out_tlast;

  always_comb begin
    pkt_next = pkt_cnt;
    if (wr_last & ~rd_last)      pkt_next = pkt_cnt + (AW+1)'(1);
    else if (rd_last & ~wr_last) pkt_next = pkt_cnt - (AW+1)'(1);
  end

  // A full FIFO holding no complete packet falls back to cut-through until a tlast leaves
  assign ct_next  = (count_next == FULL) | (ct & ~rd_last);
  assign vld_next = (count_next != '0) & ((pkt_next != '0) | ct_next);

  always_ff @(posedge aclk) begin
    if (areset) begin
      pkt_cnt <= '0;
      ct      <= 1'b0;
    end else begin
      pkt_cnt <= pkt_next;
      ct      <= ct_next;
    end
  end
`else
  assign vld_next = (count_next != '0);
`endif

  always_ff @(posedge aclk) begin
    if (areset) begin
      count      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      in_tready  <= 1'b0;
      out_tvalid <= 1'b0;
    end else begin
      count      <= count_next;
      wr_ptr     <= wr_ptr + AW'(wr);
      rd_ptr     <= rd_ptr_next;
      in_tready  <= (count_next < FULL);
      out_tvalid <= vld_next;
    end
  end

  skid_fifo_crd_ram #(
    .W     (BW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .aclk   (aclk),
    .areset (areset),
    .we     (wr),
    .waddr  (wr_ptr),
    .wdata  (wbeat),
    .raddr  (rd_ptr_next),
    .bypass (bypass),
    .rdata  (rdata)
  );

  assign head      = beat_t'(rdata);
  assign out_tdata = head.tdata;
  assign out_tkeep = head.tkeep;
  assign out_tlast = head.tlast;
  assign occupancy = count;

endmodule

// File: tb/tb_skid_fifo_crd.sv
// Self-checking bench for skid_fifo_crd: vector table, corner sequences and a random soak
// against a queue-based reference model.
module tb_skid_fifo_crd;

  localparam int unsigned N     = 4;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 2;
  localparam int unsigned NB    = 32;
  localparam int unsigned TOTAL = 5000;
  localparam int unsigned LIMIT = 60000;

  logic          aclk = 1'b0;
  logic          areset;
  logic [NB-1:0] in_tdata;
  logic [N-1:0]  in_tkeep;
  logic          in_tlast, in_tvalid, in_tready;
  logic [NB-1:0] out_tdata;
  logic [N-1:0]  out_tkeep;
  logic          out_tlast, out_tvalid, out_tready;
  logic [AW:0]   occupancy;

  always #5 aclk = ~aclk;

  skid_fifo_crd #(.N(N), .DEPTH(DEPTH)) dut (
    .aclk(aclk), .areset(areset),
    .in_tdata(in_tdata), .in_tkeep(in_tkeep), .in_tlast(in_tlast),
    .in_tvalid(in_tvalid), .in_tready(in_tready),
    .out_tdata(out_tdata), .out_tkeep(out_tkeep), .out_tlast(out_tlast),
    .out_tvalid(out_tvalid), .out_tready(out_tready),
    .occupancy(occupancy)
  );

  typedef struct packed {
    logic [NB-1:0] d;
    logic [N-1:0]  k;
    logic          l;
  } beat_t;

  typedef struct {
    logic          vld;
    logic [NB-1:0] d;
    logic [N-1:0]  k;
    logic          ordy;
    int unsigned   occ;
    logic          rdy;
    logic          ovld;
    logic [NB-1:0] od;
    logic [N-1:0]  ok;
  } vec_t;

  beat_t       q[$];
  bit          ct;
  int unsigned tests, fails, cnt_wr, cnt_rd;
  logic        last_wr, last_rd;
  vec_t        tbl [15];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic int unsigned lasts_stored();
    int unsigned n = 0;
    foreach (q[i]) if (q[i].l) n++;
    return n;
  endfunction

  // One clock: apply the handshakes to the model at the edge, then compare #1 later
  task automatic cycle();
    beat_t b;
    logic  rst, exp_rdy, exp_vld;
    bit    popped_last;
    last_wr = in_tvalid & in_tready;
    last_rd = out_tvalid & out_tready;
    @(posedge aclk);
    rst = areset;
    popped_last = 0;
    if (rst) begin
      q.delete();
      ct = 0;
    end else begin
      if (last_rd === 1'b1) begin
        chk("read_when_empty", 64'(q.size() == 0), 64'(0));
        if (q.size() != 0) begin
          b = q.pop_front();
          popped_last = b.l;
          cnt_rd++;
        end
      end
      if (last_wr === 1'b1) begin
        q.push_back({in_tdata, in_tkeep, in_tlast});
        cnt_wr++;
      end
      ct = (ct && !popped_last) || (q.size() == DEPTH);
    end
    exp_rdy = !rst && (q.size() < DEPTH);
`ifdef SKID_FIFO_CRD_PACKET_MODE_EN
    exp_vld = (q.size() > 0) && ((lasts_stored() > 0) || ct);
`else
    exp_vld = (q.size() > 0);
`endif
    #1;
    chk("occupancy", 64'(occupancy), 64'(q.size()));
    chk("in_tready", 64'(in_tready), 64'(exp_rdy));
    chk("out_tvalid", 64'(out_tvalid), 64'(exp_vld));
    if (exp_vld) begin
      chk("out_tdata", 64'(out_tdata), 64'(q[0].d));
      chk("out_tkeep", 64'(out_tkeep), 64'(q[0].k));
      chk("out_tlast", 64'(out_tlast), 64'(q[0].l));
    end
  endtask

  task automatic drive(input logic v, input logic [NB-1:0] d, input logic [N-1:0] k,
                       input logic l, input logic r);
    in_tvalid = v; in_tdata = d; in_tkeep = k; in_tlast = l; out_tready = r;
  endtask

  initial begin
    logic [NB-1:0] snap_d;
    logic [N-1:0]  snap_k;
    logic          snap_l;
    int unsigned   base_r, base_w, sent, pause, rd_left, cyc;

    tests = 0; fails = 0; cnt_wr = 0; cnt_rd = 0; ct = 0;
    areset = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b0);

    tbl[0]  = '{1'b1, 32'h30313233, 4'hF, 1'b1, 1, 1'b1, 1'b1, 32'h30313233, 4'hF};
    tbl[1]  = '{1'b1, 32'h34353637, 4'h3, 1'b1, 1, 1'b1, 1'b1, 32'h34353637, 4'h3};
    tbl[2]  = '{1'b1, 32'h38396162, 4'h0, 1'b1, 1, 1'b1, 1'b1, 32'h38396162, 4'h0};
    tbl[3]  = '{1'b0, 32'h0,        4'h0, 1'b1, 0, 1'b1, 1'b0, 32'h0,        4'h0};
    tbl[4]  = '{1'b1, 32'h41424344, 4'hF, 1'b0, 1, 1'b1, 1'b1, 32'h41424344, 4'hF};
    tbl[5]  = '{1'b1, 32'h45464748, 4'h1, 1'b0, 2, 1'b1, 1'b1, 32'h41424344, 4'hF};
    tbl[6]  = '{1'b1, 32'h494a4b4c, 4'h2, 1'b0, 3, 1'b1, 1'b1, 32'h41424344, 4'hF};
    tbl[7]  = '{1'b1, 32'h4d4e4f50, 4'h4, 1'b0, 4, 1'b0, 1'b1, 32'h41424344, 4'hF};
    tbl[8]  = '{1'b1, 32'h51525354, 4'h8, 1'b0, 4, 1'b0, 1'b1, 32'h41424344, 4'hF};
    tbl[9]  = '{1'b1, 32'h51525354, 4'h8, 1'b1, 3, 1'b1, 1'b1, 32'h45464748, 4'h1};
    tbl[10] = '{1'b1, 32'h51525354, 4'h8, 1'b1, 3, 1'b1, 1'b1, 32'h494a4b4c, 4'h2};
    tbl[11] = '{1'b1, 32'h55565758, 4'hC, 1'b1, 3, 1'b1, 1'b1, 32'h4d4e4f50, 4'h4};
    tbl[12] = '{1'b0, 32'h0,        4'h0, 1'b1, 2, 1'b1, 1'b1, 32'h51525354, 4'h8};
    tbl[13] = '{1'b0, 32'h0,        4'h0, 1'b1, 1, 1'b1, 1'b1, 32'h55565758, 4'hC};
    tbl[14] = '{1'b0, 32'h0,        4'h0, 1'b1, 0, 1'b1, 1'b0, 32'h0,        4'h0};

    // Reset, then ready rises on the first edge out of reset
    cycle(); cycle();
    areset = 1'b0;
    cycle();
    chk("ready_after_reset", 64'(in_tready), 64'(1));

    // Smoke test and fill/stall from the vector table
    for (int unsigned i = 0; i < 15; i++) begin
      drive(tbl[i].vld, tbl[i].d, tbl[i].k, 1'b1, tbl[i].ordy);
      cycle();
      chk($sformatf("tbl%0d_occ", i), 64'(occupancy), 64'(tbl[i].occ));
      chk($sformatf("tbl%0d_rdy", i), 64'(in_tready), 64'(tbl[i].rdy));
      chk($sformatf("tbl%0d_ovld", i), 64'(out_tvalid), 64'(tbl[i].ovld));
      if (tbl[i].ovld) begin
        chk($sformatf("tbl%0d_odata", i), 64'(out_tdata), 64'(tbl[i].od));
        chk($sformatf("tbl%0d_okeep", i), 64'(out_tkeep), 64'(tbl[i].ok));
        chk($sformatf("tbl%0d_olast", i), 64'(out_tlast), 64'(1));
      end
    end

    // Fill, then read and write together starting from full
    for (int unsigned i = 0; i < DEPTH; i++) begin
      drive(1'b1, 32'hA000_0000 + i, 4'hF, 1'b1, 1'b0);
      cycle();
    end
    chk("full_occ", 64'(occupancy), 64'(DEPTH));
    base_r = cnt_rd;
    out_tready = 1'b1;
    for (int unsigned i = 0; i < 10; i++) begin
      if (last_wr) in_tdata = 32'hB000_0000 + i;
      cycle();
      if (i > 0) chk("full_rw_occ", 64'(occupancy), 64'(DEPTH - 1));
    end
    chk("full_rw_reads", 64'(cnt_rd - base_r), 64'(10));
    in_tvalid = 1'b0;
    for (int unsigned i = 0; i < 8; i++) cycle();
    chk("drained", 64'(occupancy), 64'(0));

    // Output held stable while stalled
    for (int unsigned i = 0; i < 2; i++) begin
      drive(1'b1, 32'hC000_0000 + i, 4'(i + 5), 1'b1, 1'b0);
      cycle();
    end
    in_tvalid = 1'b0;
    snap_d = out_tdata; snap_k = out_tkeep; snap_l = out_tlast;
    for (int unsigned i = 0; i < 3; i++) begin
      cycle();
      chk("stall_vld", 64'(out_tvalid), 64'(1));
      chk("stall_data", 64'(out_tdata), 64'(snap_d));
      chk("stall_keep", 64'(out_tkeep), 64'(snap_k));
      chk("stall_last", 64'(out_tlast), 64'(snap_l));
    end

    // Reset with three beats stored, then a fresh stream
    drive(1'b1, 32'hC000_0002, 4'h7, 1'b1, 1'b0);
    cycle();
    chk("pre_reset_occ", 64'(occupancy), 64'(3));
    areset = 1'b1;
    drive(1'b1, 32'hDEAD_BEEF, 4'hF, 1'b1, 1'b1);
    cycle();
    chk("mid_reset_occ", 64'(occupancy), 64'(0));
    chk("mid_reset_vld", 64'(out_tvalid), 64'(0));
    areset = 1'b0;
    in_tvalid = 1'b0;
    cycle();
    drive(1'b1, 32'hE0E1E2E3, 4'hA, 1'b1, 1'b1);
    cycle();
    chk("fresh_data", 64'(out_tdata), 64'(32'hE0E1E2E3));
    in_tvalid = 1'b0;
    cycle();

`ifdef SKID_FIFO_CRD_PACKET_MODE_EN
    // Store-and-forward: held back until the tlast beat is stored
    begin
      logic exp_seq [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      for (int unsigned i = 0; i < 6; i++) begin
        if (i < 3) drive(1'b1, 32'h7000_0000 + i, 4'hF, (i == 2), 1'b1);
        else       in_tvalid = 1'b0;
        cycle();
        chk($sformatf("pkt3_vld%0d", i), 64'(out_tvalid), 64'(exp_seq[i]));
      end
    end
    // Oversize packet: fallback to cut-through at full
    base_r = cnt_rd; base_w = cnt_wr; sent = 0;
    in_tvalid = 1'b0; out_tready = 1'b1;
    for (int unsigned c = 0; c < 40 && (cnt_rd - base_r) < 6; c++) begin
      if (!in_tvalid || last_wr) begin
        if (sent < 6) begin
          drive(1'b1, 32'h8000_0000 + sent, 4'(sent), (sent == 5), 1'b1);
          sent++;
        end else in_tvalid = 1'b0;
      end
      cycle();
      if (cnt_wr - base_w == DEPTH && sent == DEPTH)
        chk("pkt6_fallback_vld", 64'(out_tvalid), 64'(1));
    end
    chk("pkt6_delivered", 64'(cnt_rd - base_r), 64'(6));
    in_tvalid = 1'b0;
`endif

    // Random soak
    base_r = cnt_rd; base_w = cnt_wr; sent = 0; pause = 0; rd_left = 0; cyc = 0;
    in_tvalid = 1'b0; out_tready = 1'b0;
    while ((cnt_rd - base_r) < TOTAL && cyc < LIMIT) begin
      if (!(in_tvalid && !last_wr)) begin
        if (sent == TOTAL) in_tvalid = 1'b0;
        else if (pause > 0) begin
          pause--;
          in_tvalid = 1'b0;
        end else begin
          in_tvalid = 1'b1;
          in_tdata  = $urandom();
          in_tkeep  = 4'($urandom_range(0, 15));
          in_tlast  = (sent == TOTAL - 1) || ($urandom_range(0, 3) == 0);
          sent++;
          pause = $urandom_range(0, 3);
        end
      end
      if (rd_left == 0) begin
        if (out_tready) begin
          out_tready = 1'b0;
          rd_left = $urandom_range(1, 6);
        end else begin
          rd_left = $urandom_range(0, 6);
          out_tready = (rd_left != 0);
          if (rd_left == 0) rd_left = $urandom_range(1, 6);
        end
      end
      rd_left--;
      cycle();
      cyc++;
    end
    chk("soak_beats_read", 64'(cnt_rd - base_r), 64'(TOTAL));
    chk("soak_wr_eq_rd", 64'(cnt_wr - base_w), 64'(cnt_rd - base_r));
    chk("soak_final_occ", 64'(occupancy), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
